// File: rtl/fp_add_issue_if.sv
// Handshake and operand/result bus between the fp_add issue/collect stage and its environment.
// The slave side is the issue stage itself; the master side is the producer/consumer plus fp_add.
interface fp_add_issue_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fp_dataa;
  logic [31:0]      fp_datab;
  logic [31:0]      fp_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, fp_result, out_ready,
    input  in_ready, fp_dataa, fp_datab, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, fp_result, out_ready,
    output in_ready, fp_dataa, fp_datab, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/fp_add_issue.sv
// Issue/collect wrapper around a fixed-latency, non-stallable fp_add: a tag delay line tracks
// in-flight ops and a credit counter reserves a result-FIFO slot for every accepted op.
module fp_add_issue #(
  parameter int LATENCY = 10,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 16
) (
  input  logic          clock,
  input  logic          reset,
  fp_add_issue_if.slave bus
);
  // One stage beyond LATENCY: the result is captured on the edge after fp_add updates it.
  localparam int STAGES = LATENCY + 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  logic             acc_s;
  logic             pop_s;
  logic             in_ready_s;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  logic             dl_vld_q [STAGES];
  logic             dl_vld_d [STAGES];
  logic [TAG_W-1:0] dl_tag_q [STAGES];
  logic [TAG_W-1:0] dl_tag_d [STAGES];

  logic             wr_s;
  logic [31:0]      wr_data_s;
  logic [TAG_W-1:0] wr_tag_s;
  logic [31:0]      mem_data_q [DEPTH];
  logic [31:0]      mem_data_d [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [OCC_W-1:0] cnt_q;
  logic [OCC_W-1:0] cnt_d;
  logic             head_empty_s;

  logic             out_valid_q;
  logic             out_valid_d;
  logic [31:0]      out_data_q;
  logic [31:0]      out_data_d;
  logic [TAG_W-1:0] out_tag_q;
  logic [TAG_W-1:0] out_tag_d;

  assign in_ready_s    = (occ_q < OCC_MAX);
  assign acc_s         = bus.in_valid && in_ready_s;
  assign pop_s         = out_valid_q && bus.out_ready;
  assign wr_s          = dl_vld_q[STAGES-1];
  assign wr_data_s     = bus.fp_result;
  assign wr_tag_s      = dl_tag_q[STAGES-1];
  assign head_empty_s  = (cnt_q == OCC_W'(0)) || ((cnt_q == OCC_W'(1)) && pop_s);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;

  // Operand drive to fp_add, zeroed when nothing is issued.
  always_comb begin
    if (acc_s) begin
      bus.fp_dataa = bus.in_a;
      bus.fp_datab = bus.in_b;
    end else begin
      bus.fp_dataa = 32'h0000_0000;
      bus.fp_datab = 32'h0000_0000;
    end
  end

  // Credit count: in-flight plus buffered ops.
  always_comb begin
    occ_d = occ_q;
    case ({acc_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Valid/tag delay line aligned with the fp_add pipeline.
  always_comb begin
    dl_vld_d[0] = acc_s;
    if (acc_s) begin
      dl_tag_d[0] = bus.in_tag;
    end else begin
      dl_tag_d[0] = {TAG_W{1'b0}};
    end
    for (int i = 1; i < STAGES; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end
  end

  // Result FIFO storage, pointers and entry count.
  always_comb begin
    mem_data_d = mem_data_q;
    mem_tag_d  = mem_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (wr_s) begin
      mem_data_d[wr_ptr_q] = wr_data_s;
      mem_tag_d[wr_ptr_q]  = wr_tag_s;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, pop_s})
      2'b10:   cnt_d = cnt_q + OCC_W'(1);
      2'b01:   cnt_d = cnt_q - OCC_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Registered head: a write into an (effectively) empty FIFO goes straight to the output register.
  always_comb begin
    out_valid_d = (cnt_d != OCC_W'(0));
    if (wr_s && head_empty_s) begin
      out_data_d = wr_data_s;
      out_tag_d  = wr_tag_s;
    end else if (out_valid_d) begin
      out_data_d = mem_data_q[rd_ptr_d];
      out_tag_d  = mem_tag_q[rd_ptr_d];
    end else begin
      out_data_d = out_data_q;
      out_tag_d  = out_tag_q;
    end
  end

  // Credit and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q       <= OCC_W'(0);
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_tag_q   <= {TAG_W{1'b0}};
    end else begin
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // Delay line registers; clearing the valids discards whatever fp_add still holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_tag_q[i] <= {TAG_W{1'b0}};
      end
    end else begin
      dl_vld_q <= dl_vld_d;
      dl_tag_q <= dl_tag_d;
    end
  end

  // FIFO registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= 32'h0000_0000;
        mem_tag_q[i]  <= {TAG_W{1'b0}};
      end
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      cnt_q    <= OCC_W'(0);
    end else begin
      mem_data_q <= mem_data_d;
      mem_tag_q  <= mem_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fp_add_issue.sv
// Bench for fp_add_issue: an integer-valued fp_add stand-in, a queue model of accepted ops
// checked every cycle, and directed scenarios with hand-computed literal expectations.
module tb_fp_add_issue;
  localparam int LATENCY = 10;
  localparam int TAG_W   = 4;
  localparam int DEPTH   = 16;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  exp_t        q[$];
  logic [31:0] pipe [LATENCY+1];
  logic        m_rdy;
  logic        m_vld;
  logic        m_acc;
  logic        m_pop;

  fp_add_issue_if #(.TAG_W(TAG_W)) bus ();

  fp_add_issue #(.LATENCY(LATENCY), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic int unsigned to_int(input logic [31:0] f);
    int unsigned m;
    int          e;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]);
    m = {8'd0, 1'b1, f[22:0]};
    if (e < 127 || e > 150) return 0;
    return m >> (150 - e);
  endfunction

  function automatic logic [31:0] to_fp(input int unsigned v);
    int          p;
    logic [31:0] m;
    logic [7:0]  e;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    m = v << (23 - p);
    e = 8'(127 + p);
    return {1'b0, e, m[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return to_fp(to_int(a) + to_int(b));
  endfunction

  // fp_add stand-in: no reset, result updates LATENCY edges after the sample edge.
  always @(posedge clock) begin
    pipe[0] <= fadd(bus.fp_dataa, bus.fp_datab);
    for (int i = 1; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.fp_result = pipe[LATENCY];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
  endtask

  // Every-cycle comparison against the queue model (ops in acceptance order, each ready 12 cycles later).
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    end else begin
      m_rdy = (q.size() < DEPTH);
      m_vld = (q.size() > 0) && (q[0].rdy <= cyc);
      m_acc = bus.in_valid && m_rdy;
      m_pop = m_vld && bus.out_ready;
      chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
      if (m_vld) begin
        chk("out_data", bus.out_data, q[0].data);
        chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
      end
      chk("fp_dataa", bus.fp_dataa, m_acc ? bus.in_a : 32'h0);
      chk("fp_datab", bus.fp_datab, m_acc ? bus.in_b : 32'h0);
      chk("occ", 32'(dut.occ_q), 32'(q.size()));
      chk("occ_le_depth", 32'(int'(dut.occ_q) > DEPTH), 32'd0);
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back('{fadd(bus.in_a, bus.in_b), bus.in_tag, cyc + LATENCY + 2});
    end
  end

  initial begin
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_out_data", bus.out_data, 32'h0);
    chk("post_rst_out_tag", 32'(bus.out_tag), 32'd0);
    repeat (20) tick();

    // Single op: 1.0 + 2.0, tag 5.
    tick();
    drive(1'b1, 32'h3F800000, 32'h40000000, 4'd5);
    #1;
    chk("single_dataa", bus.fp_dataa, 32'h3F800000);
    chk("single_datab", bus.fp_datab, 32'h40000000);
    tick();
    bus.in_valid = 1'b0;
    repeat (11) tick();
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data", bus.out_data, 32'h40400000);
    chk("single_tag", 32'(bus.out_tag), 32'd5);
    tick();
    chk("single_once", 32'(bus.out_valid), 32'd0);
    repeat (5) tick();

    // Streaming: i.0 + 1.0 for i = 0..15.
    for (int i = 0; i < 16; i++) begin
      tick();
      drive(1'b1, to_fp(i), 32'h3F800000, 4'(i));
      if (i == 12) begin
        #1;
        chk("stream_first_valid", 32'(bus.out_valid), 32'd1);
        chk("stream_first_data", bus.out_data, 32'h3F800000);
        chk("stream_first_tag", 32'(bus.out_tag), 32'd0);
      end
    end
    tick();
    bus.in_valid = 1'b0;
    repeat (11) tick();
    chk("stream_last_valid", 32'(bus.out_valid), 32'd1);
    chk("stream_last_data", bus.out_data, 32'h41800000);
    chk("stream_last_tag", 32'(bus.out_tag), 32'd15);
    tick();
    chk("stream_end", 32'(bus.out_valid), 32'd0);
    repeat (3) tick();

    // Backpressure: out_ready low, offer continuously, release at cycle 30.
    acc_cnt = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      drive(1'b1, to_fp(i & 15), to_fp(100), 4'(i));
      if (i == 16) chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_accepts", 32'(acc_cnt), 32'd16);
    chk("bp_c30_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_c30_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_c30_data", bus.out_data, 32'h42C80000);
    chk("bp_c30_tag", 32'(bus.out_tag), 32'd0);
    tick();
    chk("bp_c31_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (14) tick();
    chk("bp_c45_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_c45_data", bus.out_data, 32'h42E60000);
    chk("bp_c45_tag", 32'(bus.out_tag), 32'd15);
    tick();
    chk("bp_c46_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) tick();

    // Push/pop at the credit limit, then async reset with the FIFO full.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      drive(1'b1, to_fp(i), to_fp(1), 4'(i));
    end
    tick();
    bus.out_ready = 1'b1;
    drive(1'b1, to_fp(50), to_fp(1), 4'd7);
    chk("lim_k_in_ready", 32'(bus.in_ready), 32'd0);
    chk("lim_k_occ", 32'(dut.occ_q), 32'd16);
    tick();
    bus.out_ready = 1'b0;
    chk("lim_k1_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("lim_k2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("lim_k2_occ", 32'(dut.occ_q), 32'd16);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_out_data", bus.out_data, 32'h0);
    chk("async_rst_out_tag", 32'(bus.out_tag), 32'd0);
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();

    // Reset mid-flight: five ops discarded, then a fresh op 5.0 + 2.0, tag 9.
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, to_fp(i + 1), to_fp(1), 4'(i + 1));
    end
    tick();
    bus.in_valid = 1'b0;
    tick();
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("mid_rst_no_valid", 32'(bus.out_valid), 32'd0);
    tick();
    drive(1'b1, 32'h40A00000, 32'h40000000, 4'd9);
    tick();
    bus.in_valid = 1'b0;
    repeat (11) tick();
    chk("post_rst_op_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_op_data", bus.out_data, 32'h40E00000);
    chk("post_rst_op_tag", 32'(bus.out_tag), 32'd9);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
